// File: rtl/topk_pkg.sv
// Shared definitions for the streaming top-K selector: FSM state encoding,
// default geometry constants and the score comparator.
// Build option: define TOPK_SIGNED_EN to compare scores as two's-complement
// signed values; left undefined, scores compare as unsigned.
package topk_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_e;

    localparam int DEF_K       = 8;
    localparam int DEF_SCORE_W = 16;
    localparam int DEF_ID_W    = 7;

    // Comparator operand width; callers zero-extend their scores to this.
    localparam int CMP_W = 64;

    // Strict "a beats b" for w-bit scores. Signed mode flips the sign bit so
    // a single unsigned magnitude compare orders two's-complement values.
    function automatic logic score_gt(input logic [CMP_W-1:0] a,
                                      input logic [CMP_W-1:0] b,
                                      input int               w);
        logic [CMP_W-1:0] mask;
        logic [CMP_W-1:0] ax;
        logic [CMP_W-1:0] bx;
        logic [CMP_W-1:0] sbit;
        mask = (w >= CMP_W) ? '1 : ((CMP_W'(1) << w) - CMP_W'(1));
        sbit = CMP_W'(1) << (w - 1);
        ax   = a & mask;
        bx   = b & mask;
`ifdef TOPK_SIGNED_EN
        ax   = ax ^ sbit;
        bx   = bx ^ sbit;
`else
        ax   = ax | (sbit & ~sbit);
`endif
        return ax > bx;
    endfunction

endpackage

// File: rtl/topk_slot.sv
// One entry of the sorted winner array. Flags whether a new beat outranks
// it, and on an accepted beat either holds, takes the new pair, or takes
// the pair shifting down from the slot above.
module topk_slot
    import topk_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ins_en_i,
    input  logic               clr_i,
    input  logic [SCORE_W-1:0] new_score_i,
    input  logic [ID_W-1:0]    new_id_i,
    input  logic               upper_beats_i,
    input  logic [SCORE_W-1:0] upper_score_i,
    input  logic [ID_W-1:0]    upper_id_i,
    input  logic               upper_filled_i,
    output logic               beats_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [ID_W-1:0]    id_o,
    output logic               filled_o
);

    logic [SCORE_W-1:0] score_q, score_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               filled_q, filled_d;

    // An empty slot is always beaten; ties keep the earlier arrival in place.
    always_comb begin
        beats_o = !filled_q || score_gt(CMP_W'(new_score_i), CMP_W'(score_q), SCORE_W);
    end

    // Insertion point is the first beaten slot; every beaten slot below it shifts down.
    always_comb begin
        score_d  = score_q;
        id_d     = id_q;
        filled_d = filled_q;
        if (clr_i) begin
            filled_d = 1'b0;
        end else if (ins_en_i && beats_o) begin
            if (upper_beats_i) begin
                score_d  = upper_score_i;
                id_d     = upper_id_i;
                filled_d = upper_filled_i;
            end else begin
                score_d  = new_score_i;
                id_d     = new_id_i;
                filled_d = 1'b1;
            end
        end
    end

    // Slot storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q  <= '0;
            id_q     <= '0;
            filled_q <= 1'b0;
        end else begin
            score_q  <= score_d;
            id_q     <= id_d;
            filled_q <= filled_d;
        end
    end

    assign score_o  = score_q;
    assign id_o     = id_q;
    assign filled_o = filled_q;

endmodule

// File: rtl/topk_sorter.sv
// Streaming top-K selector: insertion-sorts incoming (score, id) pairs into
// K slots during COLLECT, then drains the winners highest-first in DRAIN.
// Build option: TOPK_SIGNED_EN selects signed score comparison (see topk_pkg).
module topk_sorter
    import topk_pkg::*;
#(
    parameter int K       = DEF_K,
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SCORE_W-1:0]      in_score,
    input  logic [ID_W-1:0]         in_id,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SCORE_W-1:0]      out_score,
    output logic [ID_W-1:0]         out_id,
    output logic                    out_last,
    output logic [K*ID_W-1:0]       out_ids_packed,
    output logic [$clog2(K+1)-1:0]  out_count
);

    localparam int CNT_W = $clog2(K + 1);
    localparam int PTR_W = $clog2(K);

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;

    // Chain index 0 is a constant "above slot 0" stub; slot gi sits at gi+1.
    logic [K:0]         beats_chain;
    logic [K:0]         filled_chain;
    logic [SCORE_W-1:0] score_chain [K+1];
    logic [ID_W-1:0]    id_chain    [K+1];
    logic               unused_tail_beats;

    logic               ins_en;
    logic               clr;
    logic [CNT_W-1:0]   fill_cnt;
    logic [CNT_W-1:0]   rd_sel;

    assign beats_chain[0]    = 1'b0;
    assign filled_chain[0]   = 1'b0;
    assign score_chain[0]    = '0;
    assign id_chain[0]       = '0;
    assign unused_tail_beats = beats_chain[K];

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == DRAIN);
    assign ins_en    = in_ready && in_valid;
    assign clr       = out_valid && out_ready && out_last;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_slot
            topk_slot #(
                .SCORE_W (SCORE_W),
                .ID_W    (ID_W)
            ) u_slot (
                .clk            (clk),
                .rst_n          (rst_n),
                .ins_en_i       (ins_en),
                .clr_i          (clr),
                .new_score_i    (in_score),
                .new_id_i       (in_id),
                .upper_beats_i  (beats_chain[gi]),
                .upper_score_i  (score_chain[gi]),
                .upper_id_i     (id_chain[gi]),
                .upper_filled_i (filled_chain[gi]),
                .beats_o        (beats_chain[gi+1]),
                .score_o        (score_chain[gi+1]),
                .id_o           (id_chain[gi+1]),
                .filled_o       (filled_chain[gi+1])
            );
            assign out_ids_packed[gi*ID_W +: ID_W] = filled_chain[gi+1] ? id_chain[gi+1] : '0;
        end
    endgenerate

    // Filled slots are contiguous from slot 0, so the popcount is the fill level.
    always_comb begin
        fill_cnt = '0;
        for (int i = 1; i <= K; i++) begin
            fill_cnt = fill_cnt + CNT_W'(filled_chain[i]);
        end
    end

    assign out_count = fill_cnt;
    assign rd_sel    = CNT_W'(ptr_q) + CNT_W'(1);
    assign out_score = out_valid ? score_chain[rd_sel] : '0;
    assign out_id    = out_valid ? id_chain[rd_sel] : '0;
    assign out_last  = out_valid && (CNT_W'(ptr_q) == (fill_cnt - CNT_W'(1)));

    // Batch FSM and drain read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    ptr_q <= '0;
                    if (in_valid && in_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state_q <= COLLECT;
                            ptr_q   <= '0;
                        end else begin
                            ptr_q <= ptr_q + PTR_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= COLLECT;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_topk_sorter.sv
// Self-checking bench for topk_sorter (K=8, SCORE_W=16, ID_W=7).
// Expected drain order comes from an independent selection model pushed to a
// scoreboard queue when each batch's last beat is driven.
module tb_topk_sorter;

    localparam int K  = 8;
    localparam int SW = 16;
    localparam int IW = 7;
    localparam int CW = $clog2(K + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_score = '0;
    logic [IW-1:0] in_id = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_score;
    logic [IW-1:0] out_id;
    logic          out_last;
    logic [K*IW-1:0] out_ids_packed;
    logic [CW-1:0] out_count;

    typedef struct {
        logic [SW-1:0] s;
        logic [IW-1:0] id;
        logic          last;
    } ent_t;

    ent_t            exp_q[$];
    ent_t            batch[$];
    logic [K*IW-1:0] exp_packed = '0;
    int              exp_count = 0;
    int              checks = 0;
    int              errors = 0;

    topk_sorter #(.K(K), .SCORE_W(SW), .ID_W(IW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_score       (in_score),
        .in_id          (in_id),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_score      (out_score),
        .out_id         (out_id),
        .out_last       (out_last),
        .out_ids_packed (out_ids_packed),
        .out_count      (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit gt(input logic [SW-1:0] a, input logic [SW-1:0] b);
`ifdef TOPK_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Reference: pick the K best by (score desc, arrival asc).
    task automatic score_batch();
        int   n;
        int   m;
        int   best;
        bit   taken [64];
        ent_t e;
        n = batch.size();
        m = (n < K) ? n : K;
        for (int i = 0; i < 64; i++) taken[i] = 1'b0;
        exp_packed = '0;
        exp_count  = m;
        for (int k = 0; k < m; k++) begin
            best = -1;
            for (int i = 0; i < n; i++) begin
                if (!taken[i] && (best < 0 || gt(batch[i].s, batch[best].s))) best = i;
            end
            taken[best] = 1'b1;
            e = batch[best];
            e.last = (k == m - 1);
            exp_q.push_back(e);
            exp_packed[k*IW +: IW] = e.id;
        end
        batch.delete();
    endtask

    task automatic send(input logic [SW-1:0] s, input logic [IW-1:0] id, input logic last);
        ent_t e;
        in_valid = 1'b1;
        in_score = s;
        in_id    = id;
        in_last  = last;
        chk("in_ready", 64'(in_ready), 64'd1);
        e.s = s;
        e.id = id;
        e.last = 1'b0;
        batch.push_back(e);
        if (last) score_batch();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) chk("latency_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic drain(input int stall_at, input int max_n);
        int   idx;
        int   n;
        ent_t e;
        idx = 0;
        while (exp_q.size() > 0 && idx < max_n) begin
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("drain_valid", 64'(out_valid), 64'd1);
            e = exp_q.pop_front();
            $display("drain entry %0d: score=0x%0h id=%0d last=%0b", idx, out_score, out_id, out_last);
            chk("out_score", 64'(out_score), 64'(e.s));
            chk("out_id", 64'(out_id), 64'(e.id));
            chk("out_last", 64'(out_last), 64'(e.last));
            chk("out_count", 64'(out_count), 64'(exp_count));
            chk("out_ids_packed", 64'(out_ids_packed), 64'(exp_packed));
            if (idx == stall_at) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_score  = '1;
                in_id     = 7'h55;
                in_last   = 1'b1;
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    chk("stall_score", 64'(out_score), 64'(e.s));
                    chk("stall_id", 64'(out_id), 64'(e.id));
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                end
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            idx++;
        end
        if (exp_q.size() == 0) begin
            chk("post_in_ready", 64'(in_ready), 64'd1);
            chk("post_out_valid", 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_score", 64'(out_score), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        chk("rst_packed", 64'(out_ids_packed), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ascending scores: top 8 of 16, with a 4-cycle stall mid-drain.
        for (int i = 0; i < 16; i++) send(SW'(100 + i), IW'(i), i == 15);
        drain(2, 100);

        // Partial fill, back-to-back with previous drain.
        send(SW'(5), IW'(1), 1'b0);
        send(SW'(9), IW'(2), 1'b0);
        send(SW'(7), IW'(3), 1'b1);
        drain(-1, 100);

        // Equal scores: arrival order wins, latecomers dropped.
        for (int i = 1; i <= 10; i++) send(SW'(50), IW'(i), i == 10);
        drain(-1, 100);

        // Sign-sensitive ordering.
        send(16'hFFFF, IW'(1), 1'b0);
        send(16'h0001, IW'(2), 1'b0);
        send(16'h8000, IW'(3), 1'b1);
        drain(-1, 100);

        // Reset mid-drain, then a fresh random batch.
        for (int i = 0; i < 12; i++) send(16'($urandom_range(0, 65535)), IW'(20 + i), i == 11);
        drain(-1, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_count", 64'(out_count), 64'd0);
        chk("mid_rst_packed", 64'(out_ids_packed), 64'd0);
        exp_q.delete();
        batch.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) send(16'($urandom_range(0, 65535)), IW'(40 + i), i == 9);
        drain(-1, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
